// File: rtl/sample_iterator.sv
// sample_iterator: accepts a triangle with its bounding box and walks the box on
// the sub-sample step grid. Each cycle it emits SAMPS sample locations along one row.
// Rows advance bottom-to-top; x wraps back to the left edge at the end of each row.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnH,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
    output logic        [SAMPS-1:0]  validSamp_R14H
);

    // Two guard bits keep cursor sums and compares from wrapping near the box edge.
    localparam int WW = SIGFIG + 2;
    typedef logic signed [WW-1:0] wide_t;
    typedef enum logic [0:0] {WAIT = 1'b0, TEST = 1'b1} state_t;

    localparam wide_t ONE_W = wide_t'(1'b1);

    // Sign-extend a coordinate into the guarded cursor width.
    function automatic wide_t sext(input logic signed [SIGFIG-1:0] v);
        return wide_t'(v);
    endfunction

    // Grid pitch for the one-hot MSAA mode; anything malformed falls back to 1x.
    function automatic wide_t step_of(input logic [3:0] mode);
        wide_t st;
        case (mode)
            4'b1000: st = ONE_W << RADIX;
            4'b0100: st = ONE_W << (RADIX - 1);
            4'b0010: st = ONE_W << (RADIX - 2);
            4'b0001: st = ONE_W << (RADIX - 3);
            default: st = ONE_W << RADIX;
        endcase
        return st;
    endfunction

    state_t                    state_q;
    logic                      halt_q;
    logic signed [SIGFIG-1:0]  tri_q   [VERTS][AXIS];
    logic        [SIGFIG-1:0]  color_q [COLORS];
    logic signed [SIGFIG-1:0]  samp_q  [2][SAMPS];
    logic        [SAMPS-1:0]   vld_q;
    wide_t                     llx_q, urx_q, ury_q, step_q;
    wide_t                     curx_q, cury_q;

    wide_t                     curx_d, cury_d;
    wide_t                     in_llx_s, in_lly_s, in_urx_s, in_ury_s;
    wide_t                     adv_x_s, row_y_s;
    wide_t                     samp_x_s [SAMPS];
    logic        [SAMPS-1:0]   samp_vld_s;
    logic                      box_ok_s, wrap_s, done_s;

    // Acceptance test on the incoming box, sample positions and next cursor for this cycle.
    always_comb begin
        in_llx_s = sext(box_R13S[0][0]);
        in_lly_s = sext(box_R13S[0][1]);
        in_urx_s = sext(box_R13S[1][0]);
        in_ury_s = sext(box_R13S[1][1]);
        box_ok_s = (in_llx_s <= in_urx_s) && (in_lly_s <= in_ury_s);

        adv_x_s = curx_q + (step_q * wide_t'(SAMPS));
        row_y_s = cury_q + step_q;
        wrap_s  = (adv_x_s > urx_q);
        done_s  = wrap_s && (row_y_s > ury_q);

        if (wrap_s) begin
            curx_d = llx_q;
            cury_d = row_y_s;
        end else begin
            curx_d = adv_x_s;
            cury_d = cury_q;
        end

        samp_vld_s = '0;
        for (int s = 0; s < SAMPS; s++) begin
            samp_x_s[s]   = curx_q + (wide_t'(s) * step_q);
            samp_vld_s[s] = (samp_x_s[s] <= urx_q);
        end
    end

    // WAIT/TEST controller with all outputs and the box cursor held in registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT;
            halt_q  <= 1'b0;
            vld_q   <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            curx_q  <= '0;
            cury_q  <= '0;
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_q[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                color_q[c] <= '0;
            for (int s = 0; s < SAMPS; s++) begin
                samp_q[0][s] <= '0;
                samp_q[1][s] <= '0;
            end
        end else begin
            case (state_q)
                WAIT: begin
                    vld_q <= '0;
                    if (validTri_R13H && box_ok_s) begin
                        tri_q   <= tri_R13S;
                        color_q <= color_R13U;
                        llx_q   <= in_llx_s;
                        urx_q   <= in_urx_s;
                        ury_q   <= in_ury_s;
                        step_q  <= step_of(subSample_RnnnnU);
                        curx_q  <= in_llx_s;
                        cury_q  <= in_lly_s;
                        state_q <= TEST;
                        halt_q  <= 1'b1;
                    end else begin
                        // Empty boxes are dropped here without ever raising halt.
                        state_q <= WAIT;
                        halt_q  <= 1'b0;
                    end
                end
                TEST: begin
                    for (int s = 0; s < SAMPS; s++) begin
                        samp_q[0][s] <= samp_x_s[s][SIGFIG-1:0];
                        samp_q[1][s] <= cury_q[SIGFIG-1:0];
                    end
                    vld_q  <= samp_vld_s;
                    curx_q <= curx_d;
                    cury_q <= cury_d;
                    if (done_s) begin
                        state_q <= WAIT;
                        halt_q  <= 1'b0;
                    end else begin
                        state_q <= TEST;
                        halt_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT;
                    halt_q  <= 1'b0;
                    vld_q   <= '0;
                end
            endcase
        end
    end

    assign halt_RnnnnH    = halt_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = samp_q;
    assign validSamp_R14H = vld_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Bench for sample_iterator: directed box cases plus randomized boxes, checked
// against a reference that enumerates the step grid of each box with plain loops.
module tb_sample_iterator;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int SAMPS  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U [COLORS];
    logic signed [SIGFIG-1:0] box_R13S [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnH;
    logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS];
    logic        [SAMPS-1:0]  validSamp_R14H;

    sample_iterator #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
        .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tri_R13S(tri_R13S),
        .color_R13U(color_R13U),
        .box_R13S(box_R13S),
        .validTri_R13H(validTri_R13H),
        .subSample_RnnnnU(subSample_RnnnnU),
        .halt_RnnnnH(halt_RnnnnH),
        .tri_R14S(tri_R14S),
        .color_R14U(color_R14U),
        .sample_R14S(sample_R14S),
        .validSamp_R14H(validSamp_R14H)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: list of (x, y) row-group origins for the presented box.
    typedef struct { longint x; longint y; } grp_t;
    grp_t   exp_q[$];
    longint m_step, m_urx;
    longint p_llx, p_lly, p_urx, p_ury;
    int     p_k;

    task automatic build_model(input longint llx, lly, urx, ury, input int k);
        exp_q.delete();
        m_step = longint'(1) << (RADIX - k);
        m_urx  = urx;
        for (longint y = lly; y <= ury; y += m_step)
            for (longint x = llx; x <= urx; x += SAMPS * m_step) begin
                grp_t g;
                g.x = x;
                g.y = y;
                exp_q.push_back(g);
            end
    endtask

    task automatic present(input longint llx, lly, urx, ury, input int k);
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++)
            color_R13U[c] = SIGFIG'($urandom);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
        subSample_RnnnnU = 4'b1000 >> k;
        validTri_R13H = 1'b1;
        p_llx = llx; p_lly = lly; p_urx = urx; p_ury = ury; p_k = k;
    endtask

    // Called at a negedge with a non-empty triangle presented and the DUT idle.
    task automatic expect_run(input string name, input bit chain,
                              input longint nllx, nlly, nurx, nury, input int nk);
        logic signed [SIGFIG-1:0] held [VERTS][AXIS];
        logic        [SIGFIG-1:0] hcol [COLORS];
        int                       mask;
        longint                   sx;
        build_model(p_llx, p_lly, p_urx, p_ury, p_k);
        held = tri_R13S;
        hcol = color_R13U;
        @(posedge clk); @(negedge clk);
        check_eq({name, "_accept_halt"}, longint'(halt_RnnnnH), 1);
        check_eq({name, "_accept_vld"}, longint'(validSamp_R14H), 0);
        if (chain) present(nllx, nlly, nurx, nury, nk);
        else validTri_R13H = 1'b0;
        for (int g = 0; g < exp_q.size(); g++) begin
            @(posedge clk); @(negedge clk);
            mask = 0;
            for (int s = 0; s < SAMPS; s++) begin
                sx = exp_q[g].x + s * m_step;
                if (sx <= m_urx) mask |= (1 << s);
                check_eq($sformatf("%s_g%0d_x%0d", name, g, s), longint'(sample_R14S[0][s]), sx);
                check_eq($sformatf("%s_g%0d_y%0d", name, g, s), longint'(sample_R14S[1][s]), exp_q[g].y);
            end
            check_eq($sformatf("%s_g%0d_vld", name, g), longint'(validSamp_R14H), longint'(mask));
            check_eq($sformatf("%s_g%0d_halt", name, g), longint'(halt_RnnnnH),
                     (g == exp_q.size() - 1) ? 0 : 1);
            check_eq($sformatf("%s_g%0d_tri0", name, g), longint'(tri_R14S[0][0]), longint'(held[0][0]));
            check_eq($sformatf("%s_g%0d_triN", name, g), longint'(tri_R14S[VERTS-1][AXIS-1]),
                     longint'(held[VERTS-1][AXIS-1]));
            check_eq($sformatf("%s_g%0d_col", name, g), longint'(color_R14U[COLORS-1]),
                     longint'(hcol[COLORS-1]));
        end
        if (!chain) begin
            @(posedge clk); @(negedge clk);
            check_eq({name, "_idle_vld"}, longint'(validSamp_R14H), 0);
            check_eq({name, "_idle_halt"}, longint'(halt_RnnnnH), 0);
        end
    endtask

    task automatic expect_empty(input string name);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq($sformatf("%s_halt%0d", name, i), longint'(halt_RnnnnH), 0);
            check_eq($sformatf("%s_vld%0d", name, i), longint'(validSamp_R14H), 0);
        end
        validTri_R13H = 1'b0;
    endtask

    initial begin
        longint st, llx, lly, urx, ury;
        int     k;
        rst = 1'b0;
        validTri_R13H = 1'b0;
        present(0, 0, 0, 0, 0);
        validTri_R13H = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_halt", longint'(halt_RnnnnH), 0);
        check_eq("rst_vld", longint'(validSamp_R14H), 0);
        check_eq("rst_samp", longint'(sample_R14S[0][2]), 0);
        check_eq("rst_tri", longint'(tri_R14S[1][1]), 0);
        check_eq("rst_col", longint'(color_R14U[0]), 0);
        rst = 1'b1;
        @(negedge clk);

        // 1x, two rows of two groups
        present(0, 0, 7168, 1024, 0);
        expect_run("r034", 1'b0, 0, 0, 0, 0, 0);
        // 1x, partial last group
        present(0, 0, 5120, 0, 0);
        expect_run("r035", 1'b0, 0, 0, 0, 0, 0);
        // 4x, step 512
        present(0, 0, 1536, 512, 1);
        expect_run("r036", 1'b0, 0, 0, 0, 0, 0);
        // empty box is dropped
        present(2048, 0, 1024, 0, 0);
        expect_empty("r037");

        // reset in the second TEST cycle
        present(0, 0, 7168, 1024, 0);
        @(posedge clk); @(negedge clk);
        validTri_R13H = 1'b0;
        check_eq("r038_halt_busy", longint'(halt_RnnnnH), 1);
        @(posedge clk); @(negedge clk);
        check_eq("r038_first_vld", longint'(validSamp_R14H), 15);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_eq("r038_rst_vld", longint'(validSamp_R14H), 0);
        check_eq("r038_rst_halt", longint'(halt_RnnnnH), 0);
        check_eq("r038_rst_samp", longint'(sample_R14S[0][1]), 0);
        check_eq("r038_rst_tri", longint'(tri_R14S[0][0]), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq($sformatf("r038_post_vld%0d", i), longint'(validSamp_R14H), 0);
            check_eq($sformatf("r038_post_halt%0d", i), longint'(halt_RnnnnH), 0);
        end
        present(0, 0, 4096, 1024, 2);
        expect_run("r038_new", 1'b0, 0, 0, 0, 0, 0);

        // back-to-back with validTri held high
        present(0, 0, 4096, 0, 0);
        expect_run("r039_a", 1'b1, -1024, -1024, 2048, 1024, 1);
        expect_run("r039_b", 1'b0, 0, 0, 0, 0, 0);

        // randomized boxes in all modes
        for (int t = 0; t < 14; t++) begin
            k   = int'($urandom_range(0, 3));
            st  = longint'(1) << (RADIX - k);
            llx = (longint'($urandom_range(0, 32)) - 16) * st;
            lly = (longint'($urandom_range(0, 32)) - 16) * st;
            urx = llx + longint'($urandom_range(0, 12)) * st;
            ury = lly + longint'($urandom_range(0, 3)) * st;
            present(llx, lly, urx, ury, k);
            expect_run($sformatf("rnd%0d", t), 1'b0, 0, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
